// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv
// IJTAG TDR driving the gate1 data-mux stage: select, lock and override data, with capture readback.
// Latency: update register outputs change on the rising edge sampling ue; scan out is retimed on the falling edge.
// Backpressure: none; shift/capture/update act only while ijtag_sel is high, and the lock bit freezes updates until reset.
//
// Ports:
//   ijtag_tck / ijtag_reset        : TCK and asynchronous active-low reset
//   ijtag_sel/ce/se/ue, ijtag_si   : IJTAG access controls and scan in
//   ijtag_so                       : scan out (falling-edge retimed)
//   functional_data_in             : functional data, observed on capture when
//                                    FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN is defined
//   ijtag_select, ijtag_data_out   : mux select and override data
//   lock_status                    : update register is locked
//
// Register bit map (shift and update register alike):
//   bit 0 = select, bit 1 = lock, bits [L-1:2] = data, with L = WIDTH + 2.
// Build option FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN: capture loads functional_data_in
// into the data field instead of reading back the programmed override.
module firebird7_in_gate1_tessent_tdr_data_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             lock_status
);

    localparam int L = WIDTH + 2;

    logic [L-1:0]     sr_q, sr_d;
    logic [L-1:0]     ur_q, ur_d;
    logic             so_q, so_d;
    logic [WIDTH-1:0] cap_data;

`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN
    assign cap_data = functional_data_in;
`else
    // Readback of the programmed override; the functional input stays on the
    // port list so both builds share one footprint.
    logic unused_functional_data;
    assign unused_functional_data = ^functional_data_in;
    assign cap_data = ur_q[L-1:2];
`endif

    always_comb begin
        sr_d = sr_q;
        ur_d = ur_q;
        if (ijtag_sel) begin
            // Capture beats shift if both are ever asserted together.
            if (ijtag_ce) begin
                sr_d = {cap_data, ur_q[1], ur_q[0]};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[L-1:1]};
            end
            // Update takes the pre-edge shift contents; once the lock bit is
            // committed, nothing but reset can change the update register.
            if (ijtag_ue && !ur_q[1]) begin
                ur_d = sr_q;
            end
        end
    end

    assign so_d = sr_q[0];

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q <= '0;
            ur_q <= '0;
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    // Falling-edge retime gives the downstream TDR a half cycle of hold margin.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            so_q <= 1'b0;
        end else begin
            so_q <= so_d;
        end
    end

    assign ijtag_so       = so_q;
    assign ijtag_select   = ur_q[0];
    assign lock_status    = ur_q[1];
    assign ijtag_data_out = ur_q[L-1:2];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl;

    logic       tck = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
    logic [2:0] fdi = 3'b000;
    logic       so, o_select, o_lock;
    logic [2:0] o_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: update register as named fields, shift register as an integer 0..31.
    int       m_sr = 0;
    bit       m_select = 0, m_lock = 0;
    bit [2:0] m_data = 0;

    typedef struct {
        logic       sel, ce, se, ue, si;
        logic       e_select, e_lock;
        logic [2:0] e_data;
        logic       e_so;
    } vec_t;
    vec_t tbl [10];

    firebird7_in_gate1_tessent_tdr_data_ctrl #(.WIDTH(3)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_select       (o_select),
        .ijtag_data_out     (o_data),
        .lock_status        (o_lock)
    );

    always #5 tck = ~tck;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One TCK cycle: inputs driven away from edges, model advanced, outputs checked
    // after the rising edge and after the following falling edge.
    task automatic step(input logic s, input logic c, input logic sh, input logic u, input logic i);
        int nsr;
        int cap;
        sel = s; ce = c; se = sh; ue = u; si = i;
        nsr = m_sr;
`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN
        cap = int'(fdi);
`else
        cap = int'(m_data);
`endif
        if (s) begin
            if (c)       nsr = cap * 4 + int'(m_lock) * 2 + int'(m_select);
            else if (sh) nsr = m_sr / 2 + int'(i) * 16;
            if (u && !m_lock) begin
                m_select = bit'(m_sr % 2);
                m_lock   = bit'((m_sr / 2) % 2);
                m_data   = 3'(m_sr / 4);
            end
        end
        m_sr = nsr;
        @(posedge tck); #1;
        chk("model_select", int'(o_select), int'(m_select));
        chk("model_lock",   int'(o_lock),   int'(m_lock));
        chk("model_data",   int'(o_data),   int'(m_data));
        @(negedge tck); #1;
        chk("model_so", int'(so), m_sr % 2);
        sel = 0; ce = 0; se = 0; ue = 0; si = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_select"}, int'(o_select), 0);
        chk({tag, "_lock"},   int'(o_lock),   0);
        chk({tag, "_data"},   int'(o_data),   0);
        chk({tag, "_so"},     int'(so),       0);
    endtask

    // Asynchronous reset applied between edges, with TCK toggling while held low.
    task automatic do_reset(input string tag);
        rst_n = 0; #1;
        m_sr = 0; m_select = 0; m_lock = 0; m_data = 0;
        check_zero({tag, "_async"});
        sel = 1; se = 1; si = 1; ue = 1;
        repeat (2) @(negedge tck);
        #1;
        check_zero({tag, "_held"});
        sel = 0; se = 0; si = 0; ue = 0;
        rst_n = 1;
    endtask

    task automatic shift5(input logic [4:0] v);
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0, v[k]);
    endtask

    initial begin
        // Program override from reset, then deselected pulses that must change nothing.
        tbl[0] = '{1,0,1,0,1, 0,0,3'b000,0};
        tbl[1] = '{1,0,1,0,0, 0,0,3'b000,0};
        tbl[2] = '{1,0,1,0,1, 0,0,3'b000,0};
        tbl[3] = '{1,0,1,0,0, 0,0,3'b000,0};
        tbl[4] = '{1,0,1,0,1, 0,0,3'b000,1};
        tbl[5] = '{1,0,0,1,0, 1,0,3'b101,1};
        tbl[6] = '{0,1,0,0,0, 1,0,3'b101,1};
        tbl[7] = '{0,0,1,0,0, 1,0,3'b101,1};
        tbl[8] = '{0,0,0,1,0, 1,0,3'b101,1};
        tbl[9] = '{1,0,0,0,0, 1,0,3'b101,1};

        @(negedge tck); #1;
        do_reset("reset");

        for (int t = 0; t < 10; t++) begin
            step(tbl[t].sel, tbl[t].ce, tbl[t].se, tbl[t].ue, tbl[t].si);
            chk($sformatf("tbl%0d_select", t), int'(o_select), int'(tbl[t].e_select));
            chk($sformatf("tbl%0d_lock", t),   int'(o_lock),   int'(tbl[t].e_lock));
            chk($sformatf("tbl%0d_data", t),   int'(o_data),   int'(tbl[t].e_data));
            chk($sformatf("tbl%0d_so", t),     int'(so),       int'(tbl[t].e_so));
        end

        // Lock: commit select=1 lock=1 data=011, then a later update must be ignored.
        do_reset("lock_rst");
        shift5(5'b01111);
        step(1, 0, 0, 1, 0);
        shift5(5'b00000);
        step(1, 0, 0, 1, 0);
        chk("lock_select", int'(o_select), 1);
        chk("lock_status", int'(o_lock),   1);
        chk("lock_data",   int'(o_data),   3);
        do_reset("lock_clear");

        // Capture: ur = data 110, select 1; functional data 001.
        shift5(5'b11001);
        step(1, 0, 0, 1, 0);
        fdi = 3'b001;
        begin
            logic [4:0] exp_so;
`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN
            exp_so = 5'b00101;
`else
            exp_so = 5'b11001;
`endif
            step(1, 1, 0, 0, 0);
            chk("cap_so0", int'(so), int'(exp_so[0]));
            for (int k = 1; k < 5; k++) begin
                step(1, 0, 1, 0, 0);
                chk($sformatf("cap_so%0d", k), int'(so), int'(exp_so[k]));
            end
        end

        // Simultaneous ue+se: ur takes 10101, sr becomes 01010.
        do_reset("sim_rst");
        shift5(5'b10101);
        step(1, 0, 1, 1, 0);
        chk("sim_select", int'(o_select), 1);
        chk("sim_lock",   int'(o_lock),   0);
        chk("sim_data",   int'(o_data),   5);
        chk("sim_so",     int'(so),       0);
        begin
            logic [4:0] rest;
            rest = 5'b01010;
            for (int k = 1; k < 5; k++) begin
                step(1, 0, 1, 0, 0);
                chk($sformatf("sim_sr_bit%0d", k), int'(so), int'(rest[k]));
            end
        end

        // Reset mid-shift: shift register must come back empty.
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        do_reset("midshift");
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1, 0, 0);
            chk($sformatf("midshift_sr%0d", k), int'(so), 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            fdi = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
            step(logic'($urandom_range(0, 9) != 0),
                 logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 6) == 0),
                 logic'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_data_ctrl.md
# firebird7_in_gate1_tessent_tdr_data_ctrl

IJTAG test data register (TDR) that drives the data-mux stage of the gate1 instrument. It sits directly upstream of the 3-bit data mux and produces that mux's `ijtag_select` and `ijtag_data_in`. It also supports an optional capture path that observes the functional data for readback. A lock bit freezes the override configuration until the next reset.

## Interface
Parameters:
- `WIDTH`, 3: width of the override data bus. The shift-chain length is `L = WIDTH + 2`.

Ports:
- `ijtag_tck` in 1: TCK. The only clock.
- `ijtag_reset` in 1: reset, asynchronous, active-low.
- `ijtag_sel` in 1: this TDR is selected on the scan path.
- `ijtag_ce` in 1: capture enable.
- `ijtag_se` in 1: shift enable.
- `ijtag_ue` in 1: update enable.
- `ijtag_si` in 1: scan in.
- `ijtag_so` out 1: scan out, retimed on the falling edge.
- `functional_data_in` in WIDTH: functional data, for capture observation.
- `ijtag_select` out 1: mux select. 1 means the override data is driven.
- `ijtag_data_out` out WIDTH: override data, feeds the mux `ijtag_data_in`.
- `lock_status` out 1: update register is locked.

## Operation
Shift register `sr[L-1:0]` bit map:
- bit 0 = select
- bit 1 = lock
- bits `[L-1:2]` = data

Update register `ur[L-1:0]` uses the same map. Outputs are driven as follows:
- `ijtag_select = ur[0]`
- `lock_status = ur[1]`
- `ijtag_data_out = ur[L-1:2]`

Shift-register actions apply only when `ijtag_sel` = 1:
- Capture (`ijtag_ce` = 1) has priority over shift.
- Capture loads `sr <= {cap_data, ur[1], ur[0]}`. `cap_data` is set by the configuration macro (see Configuration).
- Shift (`ijtag_se` = 1, `ijtag_ce` = 0) does `sr <= {ijtag_si, sr[L-1:1]}`. The LSB exits first.
- With neither `ijtag_ce` nor `ijtag_se` asserted, `sr` holds.
- With `ijtag_sel` = 0, `sr` holds regardless of ce/se.

Update register:
- Loads `ur <= sr` when `ijtag_sel && ijtag_ue && !ur[1]`.
- Once `ur[1]` = 1 (locked), every later update is ignored until reset.
- The locking update itself loads all bits. Select, data and lock are therefore committed together.

Scan out:
- `so_q` captures `sr[0]` on the falling edge of `ijtag_tck`.
- `ijtag_so = so_q`.

Simultaneous events:
- `ue` together with `ce` or `se` in the same cycle: `ur` takes the pre-edge `sr`. The shift/capture result lands in `sr` on that same edge.
- The IJTAG protocol never asserts `ce` and `se` together, but if it happens, capture wins.

## Timing
- `sr` and `ur` update on the rising edge of `ijtag_tck`. `so_q` updates on the falling edge.
- Update-to-output latency: outputs change on the same rising edge that samples `ue`. There is no extra pipeline stage.
- Shift latency: the bit present at `ijtag_si` reaches `ijtag_so` after L rising edges plus the following falling edge.
- Reset (`ijtag_reset` = 0) acts immediately and asynchronously, at any point including mid-shift:
  - `sr`, `ur` and `so_q` clear to 0.
  - So `ijtag_select` = 0 (functional path), `ijtag_data_out` = 0, `lock_status` = 0 and `ijtag_so` = 0.
- Reset release is sampled synchronously. The first action is taken at the first rising edge with reset high.
- Outputs are glitch-free: all are taken directly from flops.

## Configuration
Macro `FIREBIRD7_IN_GATE1_TDR_CAPTURE_OBS_EN` selects the capture source for the data field:
- Defined: `cap_data = functional_data_in`, sampled at the capture edge. This makes the functional value observable through the scan chain.
- Undefined: `cap_data = ur[L-1:2]`, i.e. a readback of the programmed override. `functional_data_in` is unused and the input stays present.
- Select and lock capture behaviour is identical in both builds.

## Test plan
Tests use WIDTH=3, L=5.

- **Reset:** hold reset low, toggle TCK.
  - Required: all outputs are 0.
  - Assert reset during a shift, then release. Required: `sr` = 0 and `ijtag_so` = 0.
- **Program override:**
  - Stimulus: sel=1, shift 5 bits LSB-first, select=1, lock=0, data=3'b101, then pulse ue.
  - Required on that rising edge: `ijtag_select` = 1 and `ijtag_data_out` = 3'b101.
- **Lock:**
  - Stimulus: program select=1, lock=1, data=3'b011. Then shift select=0, data=3'b000 and pulse ue.
  - Required: outputs stay at select 1, data 3'b011, `lock_status` 1. Only reset clears them.
- **Capture (both builds):** `ur` holds data 3'b110 and select 1; `functional_data_in` = 3'b001. Pulse ce, then shift 5.
  - Macro defined: `ijtag_so` sequence is 1, 0, 1, 0, 0.
  - Macro undefined: `ijtag_so` sequence is 1, 0, 0, 1, 1.
- **Deselected:** sel=0 with ce, se and ue pulsing.
  - Required: `sr`, `ur` and all outputs are unchanged.
- **Simultaneous ue+se:**
  - Stimulus: `sr` = 5'b10101, assert ue and se in the same cycle with si=0.
  - Required: `ur` = 5'b10101 and `sr` = 5'b01010.
  - Required: `ijtag_so` goes to 0 after the falling edge.
